maxpool_relu_2: RTL and testbench

Two-dimensional 2x2/stride-2 max-pooling stage with ReLU and unsigned saturation that produces the three-channel 12x12 pooled stream consumed by the second convolution layer. Sits between the first convolution layer (three signed channels, 24x24 raster) and the second convolution layer's input line buffers. One pooled pixel per channel per output beat, all three channels aligned on a shared valid strobe.

---
 rtl/maxpool_relu_2.sv | 137 +++++++++++++
 tb/tb_maxpool_relu_2.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_relu_2.sv
// maxpool_relu_2
//   2x2 / stride-2 max pooling with ReLU and unsigned saturation for three
//   signed channels. The input is a raster of IN_WIDTH x IN_HEIGHT pixels and
//   the output is the (IN_WIDTH/2) x (IN_HEIGHT/2) pooled grid. All three
//   channels share one set of position counters and one valid strobe.
//
// Ports
//   clk                      rising-edge clock
//   rst_n                    synchronous reset, active HIGH despite the name
//   valid_in                 one pixel per channel on each asserted cycle
//   conv_out_1..3            signed CONV_BIT-bit samples in raster order
//   max_value_1..3           pooled, rectified, saturated OUT_BIT-bit results
//   valid_out_relu           one-cycle strobe per pooled output beat
module maxpool_relu_2 #(
  parameter int CONV_BIT  = 14,
  parameter int OUT_BIT   = 12,
  parameter int IN_WIDTH  = 24,
  parameter int IN_HEIGHT = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic signed [CONV_BIT-1:0] conv_out_1,
  input  logic signed [CONV_BIT-1:0] conv_out_2,
  input  logic signed [CONV_BIT-1:0] conv_out_3,
  output logic        [OUT_BIT-1:0]  max_value_1,
  output logic        [OUT_BIT-1:0]  max_value_2,
  output logic        [OUT_BIT-1:0]  max_value_3,
  output logic                       valid_out_relu
);

  localparam int NCH    = 3;
  localparam int HALF_W = IN_WIDTH / 2;
  localparam int CW     = $clog2(IN_WIDTH);
  localparam int RW     = $clog2(IN_HEIGHT);
  localparam int HW     = CW - 1;

  // Largest representable unsigned output, expressed in the signed input width
  // (the input is wider than the output, so this value is positive).
  localparam logic signed [CONV_BIT-1:0] SAT_C = CONV_BIT'(2**OUT_BIT - 1);

  // Position counters
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Per-channel datapath
  logic signed [CONV_BIT-1:0] din    [NCH];
  logic signed [CONV_BIT-1:0] hold_q [NCH];
  logic signed [CONV_BIT-1:0] line_q [NCH][HALF_W];
  logic signed [CONV_BIT-1:0] pair   [NCH];
  logic signed [CONV_BIT-1:0] win    [NCH];
  logic        [OUT_BIT-1:0]  relu   [NCH];
  logic        [OUT_BIT-1:0]  max_q  [NCH];
  logic        [OUT_BIT-1:0]  max_d  [NCH];

  logic          valid_q, valid_d;
  logic          col_odd, row_odd, fire;
  logic [HW-1:0] idx;

  always_comb begin
    din[0] = conv_out_1;
    din[1] = conv_out_2;
    din[2] = conv_out_3;

    col_odd = col_q[0];
    row_odd = row_q[0];
    idx     = col_q[CW-1:1];
    fire    = valid_in & col_odd & row_odd;

    col_d = col_q;
    row_d = row_q;
    if (valid_in) begin
      if (col_q == CW'(IN_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IN_HEIGHT - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    for (int unsigned c = 0; c < NCH; c++) begin
      // Horizontal pair, then vertical against the pair kept from the even row.
      pair[c] = (din[c] > hold_q[c]) ? din[c] : hold_q[c];
      win[c]  = (line_q[c][idx] > pair[c]) ? line_q[c][idx] : pair[c];

      if (win[c][CONV_BIT-1]) begin
        relu[c] = '0;
      end else if (win[c] > SAT_C) begin
        relu[c] = '1;
      end else begin
        relu[c] = win[c][OUT_BIT-1:0];
      end

      max_d[c] = fire ? relu[c] : max_q[c];
    end

    valid_d = fire;
  end

  // Control and output registers; reset wins over a simultaneous valid_in.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++) begin
        max_q[c] <= '0;
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      for (int unsigned c = 0; c < NCH; c++) begin
        max_q[c] <= max_d[c];
      end
    end
  end

  // Hold registers and half-row buffer are always written before they are
  // read within a frame, so they carry no reset.
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NCH; c++) begin
      if (valid_in && !col_odd) begin
        hold_q[c] <= din[c];
      end
      if (valid_in && col_odd && !row_odd) begin
        line_q[c][idx] <= pair[c];
      end
    end
  end

  assign max_value_1    = max_q[0];
  assign max_value_2    = max_q[1];
  assign max_value_3    = max_q[2];
  assign valid_out_relu = valid_q;

endmodule

// File: tb/tb_maxpool_relu_2.sv
module tb_maxpool_relu_2;

  localparam int W  = 24;
  localparam int H  = 24;
  localparam int FR = W * H;
  localparam int NP = (W / 2) * (H / 2);

  logic               clk = 1'b0;
  logic               rst_n;
  logic               valid_in;
  logic signed [13:0] c1, c2, c3;
  logic        [11:0] m1, m2, m3;
  logic               vo;

  int          pix [3][H][W];
  bit          exp_fire;
  int          exp_v  [3];
  int          e_last [3];
  logic [35:0] got_q [$];
  logic [35:0] ref_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  maxpool_relu_2 #(
    .CONV_BIT (14),
    .OUT_BIT  (12),
    .IN_WIDTH (W),
    .IN_HEIGHT(H)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_in      (valid_in),
    .conv_out_1    (c1),
    .conv_out_2    (c2),
    .conv_out_3    (c3),
    .max_value_1   (m1),
    .max_value_2   (m2),
    .max_value_3   (m3),
    .valid_out_relu(vo)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int relu(input int v);
    if (v < 0) return 0;
    if (v > 4095) return 4095;
    return v;
  endfunction

  function automatic int wmax(input int ch, input int r0, input int c0);
    int m;
    m = pix[ch][r0][c0];
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        if (pix[ch][r0+dr][c0+dc] > m) m = pix[ch][r0+dr][c0+dc];
    return m;
  endfunction

  // Per-cycle checker: the output registers must reflect the beat sampled on
  // this same edge; between beats they hold, and reset clears them.
  always @(posedge clk) begin
    bit f;
    f = exp_fire && !rst_n;
    if (rst_n) e_last = '{0, 0, 0};
    else if (f) e_last = exp_v;
    #1;
    check("valid_out_relu", {31'd0, vo}, {31'd0, f});
    check("max_value_1", {20'd0, m1}, e_last[0]);
    check("max_value_2", {20'd0, m2}, e_last[1]);
    check("max_value_3", {20'd0, m3}, e_last[2]);
    if (vo === 1'b1) got_q.push_back({m3, m2, m1});
  end

  task automatic fill(input int pat);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (pat == 0) begin
          pix[0][r][c] = r * W + c;
          pix[1][r][c] = (r * W + c) * 13 - 3000;
          pix[2][r][c] = ((r * 7 + c * 5) % 41) * 300 - 4000;
        end else begin
          pix[0][r][c] = 0;
          pix[1][r][c] = -5;
          pix[2][r][c] = 1;
        end
      end
    if (pat == 1) begin
      pix[0][0][0] = -3;    pix[0][0][1] = 7;
      pix[0][1][0] = -8192; pix[0][1][1] = 6;
      pix[0][0][2] = 2047;  pix[0][0][3] = 2048;
      pix[0][1][2] = -1;    pix[0][1][3] = 0;
      pix[1][10][10] = 100;
      pix[2][4][6] = 8191;
      pix[2][6][6] = -8192; pix[2][6][7] = -1;
      pix[2][7][6] = -1;    pix[2][7][7] = -8192;
    end
  endtask

  task automatic drive(input bit v, input int r, input int c);
    @(negedge clk);
    rst_n    = 1'b0;
    valid_in = v;
    if (v) begin
      c1 = 14'(pix[0][r][c]);
      c2 = 14'(pix[1][r][c]);
      c3 = 14'(pix[2][r][c]);
      exp_fire = (r % 2 == 1) && (c % 2 == 1);
      if (exp_fire)
        for (int ch = 0; ch < 3; ch++) exp_v[ch] = relu(wmax(ch, r - 1, c - 1));
    end else begin
      c1 = 14'($urandom);
      c2 = 14'($urandom);
      c3 = 14'($urandom);
      exp_fire = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(negedge clk);
      rst_n    = 1'b1;
      valid_in = 1'b1;
      c1 = 14'($urandom);
      c2 = 14'($urandom);
      c3 = 14'($urandom);
      exp_fire = 1'b1;
    end
    @(negedge clk);
    rst_n    = 1'b0;
    valid_in = 1'b0;
    exp_fire = 1'b0;
  endtask

  task automatic run_frame(input int pat, input int nbeats, input bit bubbles);
    int p;
    fill(pat);
    for (int b = 0; b < nbeats; b++) begin
      p = b % FR;
      if (bubbles)
        for (int k = 0; k < 6 && $urandom_range(1, 0) == 1; k++) drive(1'b0, 0, 0);
      drive(1'b1, p / W, p % W);
    end
    drive(1'b0, 0, 0);
  endtask

  initial begin
    int k;
    rst_n    = 1'b1;
    valid_in = 1'b1;
    exp_fire = 1'b0;
    c1 = '0; c2 = '0; c3 = '0;
    do_reset(3);

    // Ramp frame, continuous input
    got_q.delete();
    run_frame(0, FR, 1'b0);
    check("ramp_strobes", got_q.size(), NP);
    if (got_q.size() == NP) begin
      check("ramp_first_ch1", {20'd0, got_q[0][11:0]}, 25);
      check("ramp_last_ch1", {20'd0, got_q[NP-1][11:0]}, 575);
      check("ramp_first_ch2", {20'd0, got_q[0][23:12]}, 0);
      check("ramp_last_ch2", {20'd0, got_q[NP-1][23:12]}, 4095);
      check("ramp_first_ch3", {20'd0, got_q[0][35:24]}, 0);
      check("ramp_last_ch3", {20'd0, got_q[NP-1][35:24]}, 4095);
      for (k = 0; k < NP; k += 11)
        check("ramp_formula_ch1", {20'd0, got_q[k][11:0]}, (2 * (k / 12) + 1) * 24 + 2 * (k % 12) + 1);
    end
    ref_q = got_q;

    // ReLU / saturation / signed compare frame
    got_q.delete();
    run_frame(1, FR, 1'b0);
    check("special_strobes", got_q.size(), NP);
    if (got_q.size() == NP) begin
      check("signed_cmp_a", {20'd0, got_q[0][11:0]}, 7);
      check("signed_cmp_b", {20'd0, got_q[1][11:0]}, 2048);
      check("relu_window100", {20'd0, got_q[65][23:12]}, 100);
      check("relu_neg_ch2", {20'd0, got_q[64][23:12]}, 0);
      check("sat_8191", {20'd0, got_q[27][35:24]}, 4095);
      check("relu_allneg_ch3", {20'd0, got_q[39][35:24]}, 0);
      check("plain_ch3", {20'd0, got_q[0][35:24]}, 1);
    end

    // Ramp with random bubbles
    got_q.delete();
    run_frame(0, FR, 1'b1);
    check("bubble_strobes", got_q.size(), NP);
    if (got_q.size() == NP && ref_q.size() == NP)
      for (k = 0; k < NP; k++) check("bubble_vs_ramp", got_q[k], ref_q[k]);

    // Partial frame, reset, then two back-to-back frames
    run_frame(0, 300, 1'b0);
    got_q.delete();
    do_reset(1);
    run_frame(0, 2 * FR, 1'b0);
    check("b2b_strobes", got_q.size(), 2 * NP);
    if (got_q.size() == 2 * NP && ref_q.size() == NP)
      for (k = 0; k < 2 * NP; k++) check("b2b_vs_ramp", got_q[k], ref_q[k % NP]);

    repeat (2) drive(1'b0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
